// File: rtl/sopc_run_ctrl.sv
// Run controller for the SOPC core: holds the core in reset, bounds the run
// length, and reports completion. Every output comes straight from a register.
module sopc_run_ctrl #(
    parameter int unsigned RST_CYCLES = 10,
    parameter int unsigned MAX_CYCLES = 100,
    parameter int unsigned CNT_WIDTH  = 32,
    parameter bit          AUTO_START = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 halt_req,
    input  logic                 pause,
    output logic                 core_rst,
    output logic                 running,
    output logic                 done,
    output logic                 timeout,
    output logic [CNT_WIDTH-1:0] cycle_cnt,
    output logic [1:0]           state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RESET = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam longint unsigned LP_LIM =
        (CNT_WIDTH >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << CNT_WIDTH) - 64'd1);
    localparam logic [CNT_WIDTH-1:0] LP_RST = CNT_WIDTH'(RST_CYCLES);
    localparam logic [CNT_WIDTH-1:0] LP_MAX = CNT_WIDTH'(MAX_CYCLES);

    if (RST_CYCLES < 1 || 64'(RST_CYCLES) > LP_LIM) begin : g_bad_rst_cycles
        $error("sopc_run_ctrl: RST_CYCLES out of range for CNT_WIDTH");
    end
    if (64'(MAX_CYCLES) > LP_LIM) begin : g_bad_max_cycles
        $error("sopc_run_ctrl: MAX_CYCLES does not fit in CNT_WIDTH");
    end

    state_t               r_state;
    logic [CNT_WIDTH-1:0] r_hold;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic                 r_core_rst;
    logic                 r_running;
    logic                 r_done;
    logic                 r_timeout;

    logic [CNT_WIDTH-1:0] w_cnt_inc;
    logic                 w_limit;

    // Saturating increment: an unlimited run parks at all-ones instead of wrapping.
    assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
    assign w_limit   = (MAX_CYCLES != 0) && (w_cnt_inc == LP_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_hold     <= '0;
            r_cnt      <= '0;
            r_core_rst <= 1'b1;
            r_running  <= 1'b0;
            r_done     <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_core_rst <= 1'b1;
                    r_running  <= 1'b0;
                    r_done     <= 1'b0;
                    if (AUTO_START || start) begin
                        r_state   <= S_RESET;
                        r_hold    <= '0;
                        r_cnt     <= '0;
                        r_timeout <= 1'b0;
                    end
                end
                S_RESET: begin
                    // Hold counter reaches RST_CYCLES before the release edge.
                    if (r_hold == LP_RST) begin
                        r_state    <= S_RUN;
                        r_core_rst <= 1'b0;
                        r_running  <= ~pause;
                    end else begin
                        r_hold <= r_hold + 1'b1;
                    end
                end
                S_RUN: begin
                    if (!pause) begin
                        r_cnt <= w_cnt_inc;
                    end
                    // Halt outranks the limit, so a coincident halt reports no timeout.
                    if (halt_req || (!pause && w_limit)) begin
                        r_state    <= S_DONE;
                        r_core_rst <= 1'b1;
                        r_running  <= 1'b0;
                        r_done     <= 1'b1;
                        r_timeout  <= ~halt_req;
                    end else begin
                        r_running <= ~pause;
                    end
                end
                S_DONE: begin
                    if (start) begin
                        r_state   <= S_RESET;
                        r_hold    <= '0;
                        r_cnt     <= '0;
                        r_done    <= 1'b0;
                        r_timeout <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign core_rst  = r_core_rst;
    assign running   = r_running;
    assign done      = r_done;
    assign timeout   = r_timeout;
    assign cycle_cnt = r_cnt;
    assign state     = r_state;

endmodule
